csr_file: RTL and testbench

Machine/user counter and CSR register file for the RV32 core. It executes the full Zicsr operation set (CSRRW/RS/RC and their immediate forms) against a small set of CSRs: free-running cycle and retired-instruction counters with parametrised width, a counter-inhibit register, and mscratch. It sits beside the execute stage and returns the old CSR value for rd in the same cycle; any write commits at the next clock edge.

---
 rtl/csr_if.sv | 30 +++
 rtl/csr_file.sv | 147 ++++++++++++++
 tb/tb_csr_file.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// CSR access bus between the execute stage and the CSR file.
//   csr_en      : a valid Zicsr instruction is in the stage this cycle
//   func3       : Zicsr operation (RW/RS/RC and immediate forms)
//   csr_addr    : 12-bit CSR address
//   rs1_idx     : rs1 field, doubles as the 5-bit immediate
//   rs1_data    : rs1 register value
//   retire      : one instruction retires this cycle
//   csr_rdata   : pre-write value of the addressed CSR (0 when illegal)
//   csr_illegal : the access is illegal and changes no state
// master = pipeline side, slave = CSR file side.
interface csr_if;
    logic        csr_en;
    logic [2:0]  func3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_en, func3, csr_addr, rs1_idx, rs1_data, retire,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_en, func3, csr_addr, rs1_idx, rs1_data, retire,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine/user counter and CSR register file for the RV32 core.
// Executes CSRRW/RS/RC and their immediate forms against cycle/instret
// counters (CNT_W bits, 32..64), mcountinhibit (CY, IR) and mscratch.
// Ports:
//   clk : core clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : csr_if slave modport (request, retire pulse, read data, illegal flag)
// Read data and the illegal flag are combinational; writes commit at the
// next rising edge.
module csr_file #(
    parameter int CNT_W = 64
) (
    input  logic  clk,
    input  logic  rst,
    csr_if.slave  bus
);
    localparam int NCNT = 2;  // 0 = cycle, 1 = instret

    // Counters zero-extended to 64 bits so the high half is always bits 63:32,
    // which reads 0 automatically when CNT_W = 32.
    logic [NCNT-1:0][63:0] cnt_ext;
    logic [NCNT-1:0]       cnt_inc;
    logic [NCNT-1:0]       sel_lo;
    logic [NCNT-1:0]       sel_hi;

    logic        inh_cy_q, inh_cy_d;
    logic        inh_ir_q, inh_ir_d;
    logic [31:0] mscratch_q, mscratch_d;

    logic        sel_inh;
    logic        sel_scr;
    logic        mapped;
    logic [31:0] old_val;
    logic [31:0] src;
    logic [31:0] new_val;
    logic        func_ok;
    logic        wr_intent;
    logic        read_only;
    logic        illegal;
    logic        wr_en;

    // Address decode and old-value mux. User and machine counter addresses
    // alias onto the same counter.
    always_comb begin
        sel_lo  = '0;
        sel_hi  = '0;
        sel_inh = 1'b0;
        sel_scr = 1'b0;
        mapped  = 1'b1;
        old_val = '0;
        case (bus.csr_addr)
            12'hC00, 12'hB00: begin sel_lo[0] = 1'b1; old_val = cnt_ext[0][31:0];  end
            12'hC80, 12'hB80: begin sel_hi[0] = 1'b1; old_val = cnt_ext[0][63:32]; end
            12'hC02, 12'hB02: begin sel_lo[1] = 1'b1; old_val = cnt_ext[1][31:0];  end
            12'hC82, 12'hB82: begin sel_hi[1] = 1'b1; old_val = cnt_ext[1][63:32]; end
            12'h320: begin
                sel_inh = 1'b1;
                old_val = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
            end
            12'h340: begin
                sel_scr = 1'b1;
                old_val = mscratch_q;
            end
            default: mapped = 1'b0;
        endcase
    end

    assign src       = bus.func3[2] ? {27'b0, bus.rs1_idx} : bus.rs1_data;
    assign func_ok   = (bus.func3[1:0] != 2'b00);
    // RS/RC with a zero rs1 field are pure reads, so they never trip the
    // read-only check.
    assign wr_intent = (bus.func3[1:0] == 2'b01) || (bus.rs1_idx != 5'd0);
    assign read_only = (bus.csr_addr[11:10] == 2'b11);
    assign illegal   = bus.csr_en & (~mapped | ~func_ok | (wr_intent & read_only));
    assign wr_en     = bus.csr_en & ~illegal & wr_intent;

    always_comb begin
        case (bus.func3[1:0])
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = src;
        endcase
    end

    assign bus.csr_rdata   = (bus.csr_en & ~illegal & ~rst) ? old_val : 32'h0;
    assign bus.csr_illegal = illegal;

    // Increment decisions use the inhibit bits as they stand before any
    // write in this cycle.
    assign cnt_inc[0] = ~inh_cy_q;
    assign cnt_inc[1] = bus.retire & ~inh_ir_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign cnt_ext[gi] = 64'(cnt_q);

            // A write to either half blocks the increment of that counter;
            // truncation drops high-half bits beyond CNT_W.
            always_comb begin
                cnt_d = cnt_q;
                if (wr_en && sel_lo[gi]) begin
                    cnt_d = CNT_W'({cnt_ext[gi][63:32], new_val});
                end else if (wr_en && sel_hi[gi]) begin
                    cnt_d = CNT_W'({new_val, cnt_ext[gi][31:0]});
                end else if (cnt_inc[gi]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        inh_cy_d   = inh_cy_q;
        inh_ir_d   = inh_ir_q;
        mscratch_d = mscratch_q;
        if (wr_en && sel_inh) begin
            inh_cy_d = new_val[0];
            inh_ir_d = new_val[2];
        end
        if (wr_en && sel_scr) begin
            mscratch_d = new_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_cy_q   <= 1'b0;
            inh_ir_q   <= 1'b0;
            mscratch_q <= '0;
        end else begin
            inh_cy_q   <= inh_cy_d;
            inh_ir_q   <= inh_ir_d;
            mscratch_q <= mscratch_d;
        end
    end
endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RC  = 3'b011;
    localparam logic [2:0] F_RWI = 3'b101;
    localparam logic [2:0] F_RCI = 3'b111;
    localparam logic [2:0] F_BAD = 3'b100;

    typedef struct {
        logic        en;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        ret;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    csr_if bus64();
    csr_if bus32();

    assign bus32.csr_en   = bus64.csr_en;
    assign bus32.func3    = bus64.func3;
    assign bus32.csr_addr = bus64.csr_addr;
    assign bus32.rs1_idx  = bus64.rs1_idx;
    assign bus32.rs1_data = bus64.rs1_data;
    assign bus32.retire   = bus64.retire;

    csr_file #(.CNT_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
    csr_file #(.CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    always #5 clk = ~clk;

    // Reference model: counters as plain integers reduced modulo 2^CNT_W.
    longint unsigned m_cnt [2][2];   // [variant: 0 = 64-bit, 1 = 32-bit][0 = cycle, 1 = instret]
    longint unsigned m_mask [2];
    bit              m_cy, m_ir;
    logic [31:0]     m_scr;

    function automatic int m_kind(logic [11:0] a);
        case (a)
            12'hC00, 12'hB00: return 0;
            12'hC80, 12'hB80: return 1;
            12'hC02, 12'hB02: return 2;
            12'hC82, 12'hB82: return 3;
            12'h320:          return 4;
            12'h340:          return 5;
            default:          return -1;
        endcase
    endfunction

    function automatic logic [31:0] m_old(int w, int k);
        longint unsigned c;
        c = 0;
        if (k == 0 || k == 1) c = m_cnt[w][0];
        if (k == 2 || k == 3) c = m_cnt[w][1];
        if (k == 0 || k == 2) return c[31:0];
        if (k == 1 || k == 3) return c[63:32];
        if (k == 4) return {29'b0, m_ir, 1'b0, m_cy};
        if (k == 5) return m_scr;
        return 32'h0;
    endfunction

    function automatic bit m_intent(logic [2:0] f3, logic [4:0] idx);
        return (f3[1:0] == 2'b01) || (idx != 5'd0);
    endfunction

    function automatic bit m_ill(logic en, logic [2:0] f3, logic [11:0] a, logic [4:0] idx);
        return en && (m_kind(a) < 0 || f3[1:0] == 2'b00 ||
                      (m_intent(f3, idx) && a[11:10] == 2'b11));
    endfunction

    function automatic logic [31:0] m_op(logic [1:0] op, logic [31:0] o, logic [31:0] s);
        case (op)
            2'b10:   return o | s;
            2'b11:   return o & ~s;
            default: return s;
        endcase
    endfunction

    task automatic model_update();
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  idx;
        logic [31:0] src, nv;
        int          k;
        bit          wr, inc_cy, inc_ir, inc;
        if (rst) begin
            for (int w = 0; w < 2; w++) begin
                m_cnt[w][0] = 0;
                m_cnt[w][1] = 0;
            end
            m_cy  = 1'b0;
            m_ir  = 1'b0;
            m_scr = 32'h0;
            return;
        end
        f3  = bus64.func3;
        a   = bus64.csr_addr;
        idx = bus64.rs1_idx;
        k   = m_kind(a);
        wr  = bus64.csr_en && !m_ill(bus64.csr_en, f3, a, idx) && m_intent(f3, idx);
        src = f3[2] ? {27'b0, idx} : bus64.rs1_data;
        inc_cy = !m_cy;
        inc_ir = bus64.retire && !m_ir;
        for (int w = 0; w < 2; w++) begin
            nv = m_op(f3[1:0], m_old(w, k), src);
            for (int c = 0; c < 2; c++) begin
                inc = (c == 0) ? inc_cy : inc_ir;
                if (wr && k == 2 * c)
                    m_cnt[w][c] = (m_cnt[w][c] & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
                else if (wr && k == 2 * c + 1)
                    m_cnt[w][c] = (m_cnt[w][c] & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
                else if (inc)
                    m_cnt[w][c] = m_cnt[w][c] + 1;
                m_cnt[w][c] = m_cnt[w][c] & m_mask[w];
            end
        end
        nv = m_op(f3[1:0], m_old(0, k), src);
        if (wr && k == 4) begin
            m_cy = nv[0];
            m_ir = nv[2];
        end
        if (wr && k == 5) m_scr = nv;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, sample just after it,
    // then advance the model on the rising edge. which: 0 = model only,
    // 1 = also compare the 64-bit DUT against the vector, 2 = the 32-bit DUT.
    task automatic do_cycle(input logic rst_v, input vec_t v, input int which, input string name);
        logic [31:0] erd;
        logic        eill;
        @(negedge clk);
        rst            = rst_v;
        bus64.csr_en   = v.en;
        bus64.func3    = v.f3;
        bus64.csr_addr = v.addr;
        bus64.rs1_idx  = v.idx;
        bus64.rs1_data = v.data;
        bus64.retire   = v.ret;
        #1;
        eill = m_ill(v.en, v.f3, v.addr, v.idx);
        for (int w = 0; w < 2; w++) begin
            erd = (v.en && !eill && !rst_v) ? m_old(w, m_kind(v.addr)) : 32'h0;
            if (w == 0) begin
                chk({name, " model rdata64"}, bus64.csr_rdata, erd);
                chk({name, " model ill64"}, {31'b0, bus64.csr_illegal}, {31'b0, eill});
            end else begin
                chk({name, " model rdata32"}, bus32.csr_rdata, erd);
                chk({name, " model ill32"}, {31'b0, bus32.csr_illegal}, {31'b0, eill});
            end
        end
        if (which == 1) begin
            chk({name, " rdata64"}, bus64.csr_rdata, v.exp_rd);
            chk({name, " ill64"}, {31'b0, bus64.csr_illegal}, {31'b0, v.exp_ill});
        end else if (which == 2) begin
            chk({name, " rdata32"}, bus32.csr_rdata, v.exp_rd);
            chk({name, " ill32"}, {31'b0, bus32.csr_illegal}, {31'b0, v.exp_ill});
        end
        @(posedge clk);
        model_update();
        $display("cycle %s: en=%0b f3=%b addr=%h rd64=%h rd32=%h ill=%0b",
                 name, v.en, v.f3, v.addr, bus64.csr_rdata, bus32.csr_rdata, bus64.csr_illegal);
    endtask

    function automatic vec_t mk(logic en, logic [2:0] f3, logic [11:0] a, logic [4:0] idx,
                                logic [31:0] d, logic r, logic [31:0] erd, logic eill);
        vec_t v;
        v.en = en; v.f3 = f3; v.addr = a; v.idx = idx; v.data = d; v.ret = r;
        v.exp_rd = erd; v.exp_ill = eill;
        return v;
    endfunction

    vec_t tbl[$];
    logic [11:0] addrs [14];

    initial begin
        vec_t idle;
        vec_t rv;
        m_mask[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_mask[1] = 64'h0000_0000_FFFF_FFFF;
        addrs = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hB00, 12'hB80, 12'hB02,
                  12'hB82, 12'h320, 12'h340, 12'h7C0, 12'hC01, 12'h341, 12'hB01};
        idle = mk(0, 3'b000, 12'h000, 0, 0, 0, 0, 0);
        for (int w = 0; w < 2; w++) begin
            m_cnt[w][0] = 0;
            m_cnt[w][1] = 0;
        end
        m_cy = 0; m_ir = 0; m_scr = 0;

        // Directed table, starting on the first cycle after reset release.
        tbl.push_back(mk(1, F_RS,  12'hC00, 0, 0, 0, 32'h0, 0));         // cycle 1
        for (int i = 0; i < 3; i++) tbl.push_back(idle);
        tbl.push_back(mk(1, F_RS,  12'hC00, 0, 0, 0, 32'h4, 0));         // cycle 5
        for (int i = 0; i < 4; i++) tbl.push_back(idle);
        tbl.push_back(mk(1, F_RS,  12'hC00, 0, 0, 0, 32'h9, 0));         // cycle 10
        tbl.push_back(mk(1, F_RW,  12'hB00, 1, 32'hFFFF_FFFF, 0, 32'hA, 0));
        tbl.push_back(mk(1, F_RW,  12'hB80, 1, 32'h0000_0001, 0, 32'h0, 0));
        tbl.push_back(idle);                                              // carry into high half
        tbl.push_back(mk(1, F_RS,  12'hC00, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, F_RS,  12'hC80, 0, 0, 0, 32'h2, 0));
        tbl.push_back(mk(0, 3'b000, 12'h000, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk(0, 3'b000, 12'h000, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk(1, F_RWI, 12'hB02, 5, 0, 1, 32'h2, 0));          // write beats increment
        tbl.push_back(mk(1, F_RS,  12'hB02, 0, 0, 0, 32'h5, 0));
        tbl.push_back(mk(1, F_RWI, 12'h320, 4, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 3'b000, 12'h000, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk(1, F_RS,  12'hC02, 0, 0, 1, 32'h5, 0));
        tbl.push_back(mk(1, F_RS,  12'hC02, 0, 0, 0, 32'h5, 0));
        tbl.push_back(mk(1, F_RW,  12'h340, 2, 32'hA5A5_0000, 0, 32'h0, 0));
        tbl.push_back(mk(1, F_RS,  12'h340, 1, 32'h0000_00F0, 0, 32'hA5A5_0000, 0));
        tbl.push_back(mk(1, F_RCI, 12'h340, 5'h1F, 0, 0, 32'hA5A5_00F0, 0));
        tbl.push_back(mk(1, F_RS,  12'h340, 0, 0, 0, 32'hA5A5_00E0, 0));
        tbl.push_back(mk(1, F_RW,  12'hC00, 3, 32'h1234, 0, 32'h0, 1));   // read-only write
        tbl.push_back(mk(1, F_RS,  12'hC00, 0, 0, 0, 32'hF, 0));          // counter unaffected
        tbl.push_back(mk(1, F_RS,  12'h7C0, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, F_BAD, 12'h340, 1, 32'h1, 0, 32'h0, 1));
        tbl.push_back(mk(0, F_RW,  12'h340, 1, 32'hFFFF_FFFF, 0, 32'h0, 0));
        tbl.push_back(mk(1, F_RS,  12'h340, 0, 0, 0, 32'hA5A5_00E0, 0));
        tbl.push_back(mk(1, F_RC,  12'h340, 0, 32'hFFFF_FFFF, 0, 32'hA5A5_00E0, 0));

        // Reset held with accesses and retire pulses: reads return 0.
        for (int i = 0; i < 3; i++)
            do_cycle(1, mk(1, F_RS, 12'hC00, 0, 0, 1, 32'h0, 0), 1, $sformatf("rst%0d", i));

        for (int i = 0; i < tbl.size(); i++)
            do_cycle(0, tbl[i], 1, $sformatf("t%0d", i));

        // 32-bit counter wrap.
        do_cycle(0, mk(1, F_RW, 12'hB00, 1, 32'hFFFF_FFFF, 0, 0, 0), 0, "wrap_set");
        do_cycle(0, idle, 0, "wrap_idle");
        do_cycle(0, mk(1, F_RS, 12'hC00, 0, 0, 0, 32'h0, 0), 2, "wrap0");
        do_cycle(0, mk(1, F_RS, 12'hC00, 0, 0, 0, 32'h1, 0), 2, "wrap1");
        do_cycle(0, mk(1, F_RS, 12'hC80, 0, 0, 0, 32'h0, 0), 2, "wrap_hi");

        // Reset overrides a concurrent write.
        do_cycle(1, mk(1, F_RW, 12'h340, 1, 32'h5, 0, 32'h0, 0), 1, "rst_wr");
        do_cycle(0, mk(1, F_RS, 12'h340, 0, 0, 0, 32'h0, 0), 1, "rst_rd");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rv.en   = ($urandom_range(0, 3) != 0);
            rv.f3   = 3'($urandom_range(0, 7));
            rv.addr = addrs[$urandom_range(0, 13)];
            rv.idx  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            rv.data = $urandom;
            rv.ret  = 1'($urandom);
            rv.exp_rd = 0;
            rv.exp_ill = 0;
            do_cycle(($urandom_range(0, 59) == 0), rv, 0, $sformatf("r%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
